// File: rtl/sub_fsm_scheduler_if.sv
// Handshake bundle between the scheduler and the two sub-machines it alternates.
// master drives requests/dones, slave is the scheduler side.
interface sub_fsm_scheduler_if;
  logic       start;
  logic       done_a;
  logic       done_b;
  logic       en_a;
  logic       en_b;
  logic       sel;
  logic       busy;
  logic       job_done;
  logic       timeout;
  logic [3:0] round_cnt;

  modport master (
    output start, done_a, done_b,
    input  en_a, en_b, sel, busy, job_done, timeout, round_cnt
  );

  modport slave (
    input  start, done_a, done_b,
    output en_a, en_b, sel, busy, job_done, timeout, round_cnt
  );
endinterface

// File: rtl/sub_fsm_scheduler.sv
// Alternates sub-machines A and B for NUM_ROUNDS runs with a one-cycle break-before-make gap.
// Define SUB_FSM_WATCHDOG_EN to add a per-run watchdog that forces a handoff after TIMEOUT cycles.
module sub_fsm_scheduler #(
  parameter int NUM_ROUNDS = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic               clk,
  input  logic               rst,
  sub_fsm_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN_A = 2'd1,
    GAP   = 2'd2,
    RUN_B = 2'd3
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  generate
    if (NUM_ROUNDS < 1 || NUM_ROUNDS > 15) begin : g_bad_rounds
      $error("sub_fsm_scheduler: NUM_ROUNDS must be 1..15");
    end
    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
      $error("sub_fsm_scheduler: TIMEOUT must be 2..255");
    end
  endgenerate

  state_t     state_q, state_d;
  logic       en_a_q, en_a_d;
  logic       en_b_q, en_b_d;
  logic       sel_q, sel_d;
  logic       busy_q, busy_d;
  logic       job_done_q, job_done_d;
  logic [3:0] round_cnt_q, round_cnt_d;
  logic       wd_hit;

`ifdef SUB_FSM_WATCHDOG_EN
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  logic [7:0] wdog_q, wdog_d;
  logic       timeout_q, timeout_d;

  assign wd_hit = (wdog_q == WD_LAST);

  // A matching done in the expiry cycle wins, so the pulse only marks forced handoffs.
  assign timeout_d = wd_hit &&
                     ((state_q == RUN_A && !bus.done_a) ||
                      (state_q == RUN_B && !bus.done_b));

  // Counts cycles spent in the current run; re-entering a run restarts it from zero.
  assign wdog_d = ((state_d == RUN_A || state_d == RUN_B) && state_d == state_q) ?
                  wdog_q + 8'd1 : 8'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign wd_hit      = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    round_cnt_d = round_cnt_q;
    job_done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d     = RUN_A;
          round_cnt_d = 4'd0;
        end
      end
      RUN_A: begin
        if (bus.done_a || wd_hit) begin
          state_d     = GAP;
          round_cnt_d = round_cnt_q + 4'd1;
        end
      end
      RUN_B: begin
        if (bus.done_b || wd_hit) begin
          state_d     = GAP;
          round_cnt_d = round_cnt_q + 4'd1;
        end
      end
      GAP: begin
        // sel still remembers which side just ran, so it picks the opposite one.
        if (round_cnt_q == LAST_ROUND) begin
          state_d    = IDLE;
          job_done_d = 1'b1;
        end else if (sel_q) begin
          state_d = RUN_A;
        end else begin
          state_d = RUN_B;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they change on the same edge as the state.
    en_a_d = (state_d == RUN_A);
    en_b_d = (state_d == RUN_B);
    busy_d = (state_d != IDLE);
    sel_d  = sel_q;
    if (state_d == RUN_A) begin
      sel_d = 1'b0;
    end else if (state_d == RUN_B) begin
      sel_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      en_a_q      <= 1'b0;
      en_b_q      <= 1'b0;
      sel_q       <= 1'b0;
      busy_q      <= 1'b0;
      job_done_q  <= 1'b0;
      round_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      en_a_q      <= en_a_d;
      en_b_q      <= en_b_d;
      sel_q       <= sel_d;
      busy_q      <= busy_d;
      job_done_q  <= job_done_d;
      round_cnt_q <= round_cnt_d;
    end
  end

  assign bus.en_a      = en_a_q;
  assign bus.en_b      = en_b_q;
  assign bus.sel       = sel_q;
  assign bus.busy      = busy_q;
  assign bus.job_done  = job_done_q;
  assign bus.round_cnt = round_cnt_q;

  en_exclusive: assert property (@(posedge clk) disable iff (!rst) !(en_a_q && en_b_q));

endmodule

// File: tb/tb_sub_fsm_scheduler.sv
// Scoreboard bench for sub_fsm_scheduler: a 4-round instance and a 1-round instance.
// Follows the SUB_FSM_WATCHDOG_EN setting of the build.
module tb_sub_fsm_scheduler;

  localparam logic [9:0] ALL    = 10'h3FF;
  localparam logic [9:0] NO_SEL = 10'h37F;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [9:0] sb_val[$];
  logic [9:0] sb_msk[$];

  always #5 clk = ~clk;

  sub_fsm_scheduler_if bus0 ();
  sub_fsm_scheduler_if bus1 ();

  sub_fsm_scheduler #(.NUM_ROUNDS(4), .TIMEOUT(16)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  sub_fsm_scheduler #(.NUM_ROUNDS(1), .TIMEOUT(16)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Vector layout: {en_a, en_b, sel, busy, job_done, timeout, round_cnt[3:0]}
  function automatic logic [9:0] pk(input logic ea, input logic eb, input logic sl,
                                    input logic bz, input logic jd, input logic to,
                                    input logic [3:0] rc);
    return {ea, eb, sl, bz, jd, to, rc};
  endfunction

  function automatic logic [9:0] obs0();
    return {bus0.en_a, bus0.en_b, bus0.sel, bus0.busy, bus0.job_done, bus0.timeout, bus0.round_cnt};
  endfunction

  function automatic logic [9:0] obs1();
    return {bus1.en_a, bus1.en_b, bus1.sel, bus1.busy, bus1.job_done, bus1.timeout, bus1.round_cnt};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [9:0] v, input logic [9:0] m);
    sb_val.push_back(v);
    sb_msk.push_back(m);
  endtask

  task automatic idle_inputs();
    bus0.start = 1'b0; bus0.done_a = 1'b0; bus0.done_b = 1'b0;
    bus1.start = 1'b0; bus1.done_a = 1'b0; bus1.done_b = 1'b0;
  endtask

  task automatic pulse_reset();
    idle_inputs();
    #2 rst = 1'b0;
    #2 rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [9:0] ob, ex, ms;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) rst = 1'b1;
      push(10'd0, ALL);
      push(10'd0, ALL);
      tick();
      ob = obs0(); ex = sb_val.pop_front(); ms = sb_msk.pop_front(); n_tests++;
      if ((ob & ms) !== (ex & ms)) begin
        n_fail++; $display("FAIL reset dut0 c=%0d got=%b exp=%b", c, ob, ex);
      end
      ob = obs1(); ex = sb_val.pop_front(); ms = sb_msk.pop_front(); n_tests++;
      if ((ob & ms) !== (ex & ms)) begin
        n_fail++; $display("FAIL reset dut1 c=%0d got=%b exp=%b", c, ob, ex);
      end
    end
  endtask

  // Four alternating runs, each ended by its done on the third run cycle.
  task automatic test_full_job(input bit noise);
    int r, ph;
    bit isb;
    logic [9:0] ob, ex, ms;
    for (int c = 0; c < 18; c++) begin
      r = c / 4; ph = c % 4; isb = (r % 2) == 1;
      bus0.start  = (c == 0);
      bus0.done_a = (c < 16) && ph == 3 && !isb;
      bus0.done_b = (c < 16) && ph == 3 && isb;
      if (noise && c < 16) begin
        if (ph == 0) begin bus0.done_a = 1'b1; bus0.done_b = 1'b1; end
        if (ph == 1) begin
          if (isb) bus0.done_a = 1'b1; else bus0.done_b = 1'b1;
        end
        if (ph == 2) bus0.start = 1'b1;
      end
      if (c < 16) ex = (ph < 3) ? pk(!isb, isb, isb, 1'b1, 1'b0, 1'b0, 4'(r))
                                : pk(1'b0, 1'b0, isb, 1'b1, 1'b0, 1'b0, 4'(r + 1));
      else        ex = pk(1'b0, 1'b0, 1'b0, 1'b0, (c == 16), 1'b0, 4'd4);
      push(ex, (c < 16) ? ALL : NO_SEL);
      tick();
      ob = obs0(); ex = sb_val.pop_front(); ms = sb_msk.pop_front(); n_tests++;
      if ((ob & ms) !== (ex & ms)) begin
        n_fail++; $display("FAIL full_job noise=%0d c=%0d got=%b exp=%b", noise, c, ob, ex);
      end
    end
    idle_inputs();
  endtask

  // One-round job, stray starts while busy, then start held through job_done.
  task automatic test_single_round();
    logic [9:0] ob, ex, ms;
    for (int c = 0; c < 11; c++) begin
      bus1.start  = (c == 0) || (c == 2) || (c == 4) || (c == 5);
      bus1.done_a = (c == 3) || (c == 8);
      bus1.done_b = 1'b1;
      case (c)
        3, 8:    ex = pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
        4, 9:    ex = pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1);
        10:      ex = pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
        default: ex = pk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      endcase
      push(ex, ALL);
      tick();
      ob = obs1(); ex = sb_val.pop_front(); ms = sb_msk.pop_front(); n_tests++;
      if ((ob & ms) !== (ex & ms)) begin
        n_fail++; $display("FAIL single_round c=%0d got=%b exp=%b", c, ob, ex);
      end
    end
    idle_inputs();
  endtask

  // done_b and start while in RUN_A change nothing; done_a then hands off to B.
  task automatic test_ignore();
    logic [9:0] ob, ex, ms;
    for (int c = 0; c < 11; c++) begin
      bus0.start  = (c == 0) || (c == 6) || (c == 7);
      bus0.done_b = (c >= 1) && (c <= 5);
      bus0.done_a = (c == 8);
      if (c < 8)       ex = pk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      else if (c == 8) ex = pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
      else             ex = pk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1);
      push(ex, ALL);
      tick();
      ob = obs0(); ex = sb_val.pop_front(); ms = sb_msk.pop_front(); n_tests++;
      if ((ob & ms) !== (ex & ms)) begin
        n_fail++; $display("FAIL ignore c=%0d got=%b exp=%b", c, ob, ex);
      end
    end
    pulse_reset();
  endtask

  // Short runs up to RUN_B with round_cnt=3, then an asynchronous reset mid-cycle.
  task automatic test_abort();
    logic [9:0] ob, ex, ms;
    for (int c = 0; c < 8; c++) begin
      bus0.start  = (c == 0);
      bus0.done_a = (c == 1) || (c == 5);
      bus0.done_b = (c == 3);
      case (c)
        0:       ex = pk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        1:       ex = pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
        2:       ex = pk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1);
        3:       ex = pk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2);
        4:       ex = pk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2);
        5:       ex = pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3);
        default: ex = pk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3);
      endcase
      push(ex, ALL);
      tick();
      ob = obs0(); ex = sb_val.pop_front(); ms = sb_msk.pop_front(); n_tests++;
      if ((ob & ms) !== (ex & ms)) begin
        n_fail++; $display("FAIL abort_run c=%0d got=%b exp=%b", c, ob, ex);
      end
    end
    idle_inputs();
    #2 rst = 1'b0;
    push(10'd0, ALL);
    #1;
    ob = obs0(); ex = sb_val.pop_front(); ms = sb_msk.pop_front(); n_tests++;
    if ((ob & ms) !== (ex & ms)) begin
      n_fail++; $display("FAIL abort_async got=%b exp=%b", ob, ex);
    end
    for (int c = 0; c < 4; c++) begin
      if (c == 1) rst = 1'b1;
      push(10'd0, ALL);
      tick();
      ob = obs0(); ex = sb_val.pop_front(); ms = sb_msk.pop_front(); n_tests++;
      if ((ob & ms) !== (ex & ms)) begin
        n_fail++; $display("FAIL abort_idle c=%0d got=%b exp=%b", c, ob, ex);
      end
    end
  endtask

`ifdef SUB_FSM_WATCHDOG_EN
  // A never finishes and is cut off after 16 cycles; B finishes exactly at the limit.
  task automatic test_watchdog();
    logic [9:0] ob, ex, ms;
    for (int c = 0; c < 35; c++) begin
      bus0.start  = (c == 0);
      bus0.done_a = 1'b0;
      bus0.done_b = (c == 33);
      if (c < 16)       ex = pk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      else if (c == 16) ex = pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1);
      else if (c < 33)  ex = pk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1);
      else if (c == 33) ex = pk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2);
      else              ex = pk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2);
      push(ex, ALL);
      tick();
      ob = obs0(); ex = sb_val.pop_front(); ms = sb_msk.pop_front(); n_tests++;
      if ((ob & ms) !== (ex & ms)) begin
        n_fail++; $display("FAIL watchdog c=%0d got=%b exp=%b", c, ob, ex);
      end
    end
    pulse_reset();
  endtask
`else
  // Without the watchdog a run with no done never ends.
  task automatic test_no_watchdog();
    logic [9:0] ob, ex, ms;
    for (int c = 0; c < 1001; c++) begin
      bus0.start = (c == 0);
      push(pk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0), ALL);
      tick();
      ob = obs0(); ex = sb_val.pop_front(); ms = sb_msk.pop_front(); n_tests++;
      if ((ob & ms) !== (ex & ms)) begin
        n_fail++; $display("FAIL no_watchdog c=%0d got=%b exp=%b", c, ob, ex);
      end
    end
    pulse_reset();
  endtask
`endif

  initial begin
    idle_inputs();
    test_reset();
    test_full_job(1'b0);
    test_single_round();
    test_ignore();
    test_abort();
    test_full_job(1'b1);
`ifdef SUB_FSM_WATCHDOG_EN
    test_watchdog();
`else
    test_no_watchdog();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
